// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//
// Main-memory side of the data-cache handshake. Serves single-word
// write-through requests and block-fill reads after a fixed access latency,
// signalling completion with a one-cycle ready pulse.
//
// Parameters:
//   LATENCY      cycles from request acceptance to ready (1..15)
//   DEPTH_W      memory holds 2**DEPTH_W 32-bit words
//   BLOCK_WORDS  words per cache block (power of two)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   dm_re        block read request (level, held until ready)
//   dm_we        word write request (level, held until ready); wins over dm_re
//   addr         byte address, bits [1:0] ignored, wraps modulo memory size
//   wdata        write word
//   rdata_block  last block read; word k at [32k+31:32k]
//   ready        one-cycle completion pulse
//   busy         high while a transaction is in flight
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_W     = 10,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dm_re,
  input  logic                       dm_we,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [32*BLOCK_WORDS-1:0]  rdata_block,
  output logic                       ready,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Clears the in-block word offset so a read index points at the block base.
  localparam logic [DEPTH_W-1:0] OFF_MASK  = DEPTH_W'(BLOCK_WORDS - 1);
  localparam logic [3:0]         CNT_START = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic [DEPTH_W-1:0]  idx;       // word index (write) or block base (read)
  logic [31:0]         wdata_q;
  logic [DEPTH_W-1:0]  word_idx;
  logic                do_write;

  logic [31:0] mem [2**DEPTH_W];

  // Address bits outside the word index carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{addr[31:DEPTH_W+2], addr[1:0]};

  assign word_idx = addr[DEPTH_W+1:2];

  // A reset at the access edge must suppress the write, so reset gates it.
  assign do_write = reset && (state == WR_WAIT) && (cnt == 4'd0);

  // NOTE: the memory array has no reset; clearing it would force it out of
  // RAM macros into flops, and its contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= wdata_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      rdata_block <= '0;
      idx         <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_we) begin
            idx     <= word_idx;
            wdata_q <= wdata;
            cnt     <= CNT_START;
            busy    <= 1'b1;
            state   <= WR_WAIT;
          end else if (dm_re) begin
            idx   <= word_idx & ~OFF_MASK;
            cnt   <= CNT_START;
            busy  <= 1'b1;
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (cnt == 4'd0) begin
            // Whole block captured at one edge; low index bits are zero, so
            // adding k never carries out of the block.
            for (int k = 0; k < BLOCK_WORDS; k++) begin
              rdata_block[32*k +: 32] <= mem[idx + DEPTH_W'(k)];
            end
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_WAIT: begin
          if (cnt == 4'd0) begin
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          // Requests seen here are ignored; a still-held one restarts in IDLE.
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
